branch_seq_ctrl: RTL

- Sequences the ID-stage branch comparator for the P7 pipeline.
- Decides when comparator operands are valid and drives the comparator's 3-bit branch-type select.
- Stalls ID on unresolved operand hazards and issues the taken/not-taken redirect.
- Tracks the delay slot so CP0 can set Cause.BD, and aborts cleanly on an interrupt/exception flush.

---
 rtl/branch_seq_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/branch_seq_ctrl.sv
// ID-stage branch sequencer: operand-hazard stall, comparator select, redirect and delay-slot tracking.
// Optional statistics counters are built when BR_STATS_EN is defined.
module branch_seq_ctrl #(
    parameter int unsigned MAX_STALL = 8
`ifdef BR_STATS_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [2:0]       id_br_type,
    input  logic             rs_ready,
    input  logic             rt_ready,
    input  logic             freeze,
    input  logic             flush,
    input  logic             cmp_taken,
    output logic [2:0]       cmp_br,
    output logic             br_take,
    output logic             stall,
    output logic             in_dslot,
    output logic             stall_err,
    output logic             dslot_br_err
`ifdef BR_STATS_EN
    ,
    output logic [CNT_W-1:0] br_total,
    output logic [CNT_W-1:0] br_taken_cnt,
    output logic [CNT_W-1:0] br_stall_cyc
`endif
);

    localparam int unsigned WCW = $clog2(MAX_STALL + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DSLOT = 2'd2
    } stateT;

    stateT          state;
    stateT          nextState;
    logic [WCW-1:0] waitCnt;
    logic [WCW-1:0] nextWaitCnt;
    logic [2:0]     effType;
    logic           isBranch;
    logic           needRt;
    logic           ready;
    logic           resolve;
    logic           setStallErr;
    logic           setDslotErr;

    // Reserved type 7 decodes as "no branch"
    assign effType  = (id_br_type == 3'd7) ? 3'd0 : id_br_type;
    assign isBranch = id_valid && (effType != 3'd0);
    assign needRt   = (effType == 3'd1) || (effType == 3'd2);
    assign ready    = rs_ready && (!needRt || rt_ready);

    always_comb begin
        nextState   = state;
        nextWaitCnt = waitCnt;
        cmp_br      = 3'd0;
        br_take     = 1'b0;
        stall       = 1'b0;
        resolve     = 1'b0;
        setStallErr = 1'b0;
        setDslotErr = 1'b0;

        if (flush) begin
            nextState   = ST_IDLE;
            nextWaitCnt = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (isBranch) begin
                        if (!ready) begin
                            stall = 1'b1;
                            if (!freeze) begin
                                nextState   = ST_WAIT;
                                nextWaitCnt = WCW'(1);
                            end
                        end else if (!freeze) begin
                            resolve     = 1'b1;
                            nextState   = ST_DSLOT;
                            nextWaitCnt = '0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!isBranch) begin
                        nextState   = ST_IDLE;
                        nextWaitCnt = '0;
                    end else if (freeze) begin
                        stall       = 1'b1;
                        setStallErr = !ready && (waitCnt == WCW'(MAX_STALL));
                    end else if (ready) begin
                        resolve     = 1'b1;
                        nextState   = ST_DSLOT;
                        nextWaitCnt = '0;
                    end else begin
                        stall = 1'b1;
                        if (waitCnt == WCW'(MAX_STALL)) begin
                            setStallErr = 1'b1;
                        end else begin
                            nextWaitCnt = waitCnt + WCW'(1);
                        end
                    end
                end
                ST_DSLOT: begin
                    // A branch in the slot is never resolved, only flagged
                    setDslotErr = isBranch;
                    if (id_valid && !freeze) begin
                        nextState = ST_IDLE;
                    end
                end
                default: begin
                    nextState   = ST_IDLE;
                    nextWaitCnt = '0;
                end
            endcase
        end

        if (resolve) begin
            cmp_br  = effType;
            br_take = cmp_taken;
        end

        if (!reset) begin
            cmp_br  = 3'd0;
            br_take = 1'b0;
            stall   = 1'b0;
            resolve = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            waitCnt      <= '0;
            in_dslot     <= 1'b0;
            stall_err    <= 1'b0;
            dslot_br_err <= 1'b0;
        end else begin
            state    <= nextState;
            waitCnt  <= nextWaitCnt;
            in_dslot <= (nextState == ST_DSLOT);
            if (setStallErr) begin
                stall_err <= 1'b1;
            end
            if (setDslotErr) begin
                dslot_br_err <= 1'b1;
            end
        end
    end

`ifdef BR_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating branch statistics
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            br_total     <= '0;
            br_taken_cnt <= '0;
            br_stall_cyc <= '0;
        end else begin
            if (resolve && (br_total != CNT_MAX)) begin
                br_total <= br_total + CNT_W'(1);
            end
            if (resolve && br_take && (br_taken_cnt != CNT_MAX)) begin
                br_taken_cnt <= br_taken_cnt + CNT_W'(1);
            end
            if (stall && (br_stall_cyc != CNT_MAX)) begin
                br_stall_cyc <= br_stall_cyc + CNT_W'(1);
            end
        end
    end
`endif

endmodule
